// File: rtl/maxpool_stream_adapter_pkg.sv
// Shared constants, state encoding and helpers for the max-pool stream adapter.
// Module-level parameters default to these values.
package maxpool_stream_adapter_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int D          = 1;
    localparam int H          = 6;
    localparam int W          = 6;
    localparam int POOL_LAT   = 2;
    localparam int N_IN       = H * W * D;
    localparam int N_OUT      = (H - 4) * (W - 4) * D;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        WAIT   = 2'd1,
        UNLOAD = 2'd2
    } state_t;

    // Width needed to index v entries; never less than 1 bit.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        for (int i = 0; i < 32; i++) begin
            if (x > 0) begin
                r = r + 1;
                x = x >> 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/maxpool_stream_adapter_if.sv
// Valid/ready pixel stream with end-of-frame marker.
// The producer side uses the master modport.
interface maxpool_stream_adapter_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  last;
    logic                  ready;

    modport master (output data, valid, last, input ready);
    modport slave  (input data, valid, last, output ready);
endinterface

// File: rtl/maxpool_stream_adapter.sv
// Packs a pixel stream into the flat frame for the 5x5 max-pool, waits out the pool latency,
// captures its result and replays it as a pixel stream. One frame in flight at a time.
module maxpool_stream_adapter #(
    parameter int DATA_WIDTH = maxpool_stream_adapter_pkg::DATA_WIDTH,
    parameter int D          = maxpool_stream_adapter_pkg::D,
    parameter int H          = maxpool_stream_adapter_pkg::H,
    parameter int W          = maxpool_stream_adapter_pkg::W,
    parameter int POOL_LAT   = maxpool_stream_adapter_pkg::POOL_LAT
) (
    input  logic                                     clk,
    input  logic                                     reset,
    maxpool_stream_adapter_if.slave                  s,
    maxpool_stream_adapter_if.master                 m,
    output logic [0:H*W*D*DATA_WIDTH-1]              mp_input,
    input  logic [0:(H-4)*(W-4)*D*DATA_WIDTH-1]      mp_output,
    output logic                                     frame_err
);
    import maxpool_stream_adapter_pkg::*;

    localparam int N_IN  = H * W * D;
    localparam int N_OUT = (H - 4) * (W - 4) * D;
    localparam int IW    = clog2(N_IN);
    localparam int OW    = clog2(N_OUT);
    localparam int LW    = clog2(POOL_LAT + 1);

    localparam logic [IW-1:0] IN_LAST  = IW'(N_IN - 1);
    localparam logic [OW-1:0] OUT_LAST = OW'(N_OUT - 1);
    localparam logic [LW-1:0] LAT_END  = LW'(POOL_LAT);

    state_t                        state, state_nxt;
    logic                          armed;
    logic [IW-1:0]                 in_cnt;
    logic [OW-1:0]                 out_cnt;
    logic [LW-1:0]                 lat_cnt;
    logic [0:N_OUT*DATA_WIDTH-1]   out_reg;
    logic                          in_fire, in_final, out_fire, out_final, lat_done;

    // armed keeps s.ready low until the first clock edge after reset release.
    assign s.ready   = armed && (state == LOAD);
    assign in_fire   = s.valid && s.ready;
    assign in_final  = (in_cnt == IN_LAST);
    assign lat_done  = (lat_cnt == LAT_END);
    assign out_final = (out_cnt == OUT_LAST);

    assign m.valid   = (state == UNLOAD);
    assign m.last    = m.valid && out_final;
    assign m.data    = out_reg[out_cnt*DATA_WIDTH +: DATA_WIDTH];
    assign out_fire  = m.valid && m.ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= LOAD;
        else        state <= state_nxt;
    end

    // An early s.last truncates the frame: untouched slots keep the previous frame's pixels.
    always_comb begin
        state_nxt = state;
        unique case (state)
            LOAD:    if (in_fire && (in_final || s.last)) state_nxt = WAIT;
            WAIT:    if (lat_done) state_nxt = UNLOAD;
            UNLOAD:  if (out_fire && out_final) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed     <= 1'b0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            lat_cnt   <= '0;
            mp_input  <= '0;
            out_reg   <= '0;
            frame_err <= 1'b0;
        end else begin
            armed <= 1'b1;
            unique case (state)
                LOAD: begin
                    if (in_fire) begin
                        mp_input[in_cnt*DATA_WIDTH +: DATA_WIDTH] <= s.data;
                        in_cnt  <= in_cnt + IW'(1);
                        lat_cnt <= '0;
                        if (s.last != in_final) frame_err <= 1'b1;
                    end
                end
                // Capture one cycle after the count reaches POOL_LAT, i.e. POOL_LAT+1 after the last beat.
                WAIT: begin
                    if (lat_done) begin
                        out_reg <= mp_output;
                        out_cnt <= '0;
                    end else begin
                        lat_cnt <= lat_cnt + LW'(1);
                    end
                end
                UNLOAD: begin
                    if (out_fire) begin
                        out_cnt <= out_cnt + OW'(1);
                        if (out_final) in_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_maxpool_stream_adapter.sv
// Directed bench for the max-pool stream adapter with a behavioural 5x5 pool behind it.
module tb_maxpool_stream_adapter;

    localparam int DW = 16;
    localparam int H  = 6;
    localparam int W  = 6;
    localparam int D  = 1;
    localparam int PL = 2;
    localparam int NI = H * W * D;
    localparam int NO = (H - 4) * (W - 4) * D;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [0:NI*DW-1] mp_input;
    logic [0:NO*DW-1] mp_output;
    logic frame_err;
    int checks = 0;
    int failures = 0;
    int lat;
    logic [15:0] pix [NI];

    localparam logic [NI*DW-1:0] P1 = {{4{16'hBC00}}, 16'hBD00, {31{16'hC200}}};
    localparam logic [NI*DW-1:0] P3 = {{21{16'h4000}}, {15{16'hC200}}};
    localparam logic [NI*DW-1:0] P6 = {36{16'h4400}};

    maxpool_stream_adapter_if #(.DATA_WIDTH(DW)) s_if ();
    maxpool_stream_adapter_if #(.DATA_WIDTH(DW)) m_if ();

    always #5 clk = ~clk;

    maxpool_stream_adapter #(
        .DATA_WIDTH(DW), .D(D), .H(H), .W(W), .POOL_LAT(PL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s         (s_if),
        .m         (m_if),
        .mp_input  (mp_input),
        .mp_output (mp_output),
        .frame_err (frame_err)
    );

    // FP16 total-order key for max comparison.
    function automatic logic [15:0] key(input logic [15:0] v);
        return v[15] ? ~v : (v | 16'h8000);
    endfunction

    function automatic logic [0:NO*DW-1] pool(input logic [0:NI*DW-1] v);
        logic [0:NO*DW-1] r;
        logic [15:0] best, px;
        r = '0;
        for (int oy = 0; oy < H - 4; oy++)
            for (int ox = 0; ox < W - 4; ox++) begin
                best = v[(oy*W + ox)*DW +: DW];
                for (int ky = 0; ky < 5; ky++)
                    for (int kx = 0; kx < 5; kx++) begin
                        px = v[((oy + ky)*W + ox + kx)*DW +: DW];
                        if (key(px) > key(best)) best = px;
                    end
                r[(oy*(W-4) + ox)*DW +: DW] = best;
            end
        return r;
    endfunction

    logic [0:NO*DW-1] pipe [PL];
    always_ff @(posedge clk) begin
        pipe[0] <= pool(mp_input);
        for (int i = 1; i < PL; i++) pipe[i] <= pipe[i-1];
    end
    assign mp_output = pipe[PL-1];

    task automatic chk(input string tag, input logic [NI*DW-1:0] obs, input logic [NI*DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input logic [15:0] d, input logic l, input bit gap);
        bit rdy;
        int n;
        n = gap ? int'($urandom_range(0, 2)) : 0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        s_if.valid = 1'b1;
        s_if.data  = d;
        s_if.last  = l;
        rdy = 1'b0;
        for (int t = 0; t < 50 && !rdy; t++) begin
            @(negedge clk);
            rdy = s_if.ready;
            @(posedge clk);
            #1;
        end
        if (!rdy) chk("s_accept_timeout", rdy, 1);
        s_if.valid = 1'b0;
        s_if.last  = 1'b0;
    endtask

    task automatic send_frame(input int last_idx, input bit gaps);
        for (int i = 0; i <= last_idx; i++)
            send_beat(pix[i], (i == last_idx), gaps && (i > 0));
    endtask

    task automatic recv_beat(input string tag, input logic [15:0] exp, input logic exp_last, input int stall);
        bit got;
        got = 1'b0;
        m_if.ready = 1'b0;
        for (int t = 0; t < stall; t++) begin
            @(negedge clk);
            chk({tag, "_stall_valid"}, m_if.valid, 1);
            chk({tag, "_stall_data"}, m_if.data, exp);
            chk({tag, "_stall_s_ready"}, s_if.ready, 0);
            @(posedge clk);
            #1;
        end
        m_if.ready = 1'b1;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            if (m_if.valid) begin
                got = 1'b1;
                chk({tag, "_data"}, m_if.data, exp);
                chk({tag, "_last"}, m_if.last, exp_last);
                chk({tag, "_s_ready"}, s_if.ready, 0);
            end
            @(posedge clk);
            #1;
        end
        if (!got) chk({tag, "_timeout"}, got, 1);
        m_if.ready = 1'b0;
    endtask

    task automatic recv_four(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] c, input logic [15:0] e, input int stall1);
        recv_beat({tag, "_o0"}, a, 1'b0, 0);
        recv_beat({tag, "_o1"}, b, 1'b0, stall1);
        recv_beat({tag, "_o2"}, c, 1'b0, 0);
        recv_beat({tag, "_o3"}, e, 1'b1, 0);
    endtask

    initial begin
        s_if.valid = 1'b0;
        s_if.data  = '0;
        s_if.last  = 1'b0;
        m_if.ready = 1'b0;

        // Reset state
        @(posedge clk);
        #1;
        chk("rst_s_ready", s_if.ready, 0);
        chk("rst_m_valid", m_if.valid, 0);
        chk("rst_m_last", m_if.last, 0);
        chk("rst_m_data", m_if.data, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_mp_input", mp_input, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rel_s_ready_pre_clk", s_if.ready, 0);
        @(posedge clk);
        #1;
        chk("rel_s_ready_post_clk", s_if.ready, 1);

        // Basic frame, contiguous, with latency measurement
        for (int i = 0; i < NI; i++) pix[i] = (i < 4) ? 16'hBC00 : (i == 4) ? 16'hBD00 : 16'hC200;
        send_frame(35, 1'b0);
        chk("f1_mp_input", mp_input, P1);
        lat = 0;
        while (!m_if.valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("f1_latency", lat, 3);
        recv_four("f1", 16'hBC00, 16'hBC00, 16'hC200, 16'hC200, 0);
        chk("f1_frame_err", frame_err, 0);
        chk("b2b_s_ready", s_if.ready, 1);

        // Same frame with input gaps and a 5-cycle output stall
        send_frame(35, 1'b1);
        chk("f2_mp_input", mp_input, P1);
        recv_four("f2", 16'hBC00, 16'hBC00, 16'hC200, 16'hC200, 5);
        chk("f2_frame_err", frame_err, 0);

        // Early s_last on beat 20: truncated frame keeps old tail pixels
        for (int i = 0; i < NI; i++) pix[i] = 16'h4000;
        send_frame(20, 1'b0);
        chk("f3_mp_input", mp_input, P3);
        chk("f3_frame_err", frame_err, 1);
        recv_four("f3", 16'h4000, 16'h4000, 16'h4000, 16'h4000, 0);

        // Correct framing afterwards: error stays sticky
        for (int i = 0; i < NI; i++) pix[i] = (i < 4) ? 16'hBC00 : (i == 4) ? 16'hBD00 : 16'hC200;
        send_frame(35, 1'b1);
        chk("f4_mp_input", mp_input, P1);
        recv_four("f4", 16'hBC00, 16'hBC00, 16'hC200, 16'hC200, 0);
        chk("f4_frame_err_sticky", frame_err, 1);

        // Reset in the middle of UNLOAD
        for (int i = 0; i < NI; i++) pix[i] = 16'h3C00;
        send_frame(35, 1'b0);
        recv_beat("f5_o0", 16'h3C00, 1'b0, 0);
        recv_beat("f5_o1", 16'h3C00, 1'b0, 0);
        reset = 1'b0;
        #1;
        chk("f5_rst_m_valid", m_if.valid, 0);
        chk("f5_rst_m_last", m_if.last, 0);
        chk("f5_rst_frame_err", frame_err, 0);
        chk("f5_rst_mp_input", mp_input, 0);
        chk("f5_rst_s_ready", s_if.ready, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Fresh frame after reset
        for (int i = 0; i < NI; i++) pix[i] = 16'h4400;
        send_frame(35, 1'b0);
        chk("f6_mp_input", mp_input, P6);
        recv_four("f6", 16'h4400, 16'h4400, 16'h4400, 16'h4400, 0);
        chk("f6_frame_err", frame_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
